// File: rtl/fault_campaign_pkg.sv
// Shared types for the stuck-at fault campaign controller: FSM states,
// fault-index decode and the per-fault result record.
package fault_campaign_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST1,
    RST2,
    RUN,
    RECORD,
    DONE
  } state_t;

  localparam int RES_FAULT_W = 16;
  localparam int RES_CYCLE_W = 16;

  typedef struct packed {
    logic [RES_FAULT_W-1:0] fault;
    logic                   detected;
    logic [RES_CYCLE_W-1:0] cycle;
  } fault_result_t;

  typedef struct packed {
    logic [31:0] site;
    logic        stuck_hi;
  } fault_sel_t;

  // Even indices are stuck-at-0, odd are stuck-at-1 on site f>>1.
  function automatic fault_sel_t decode_fault(input logic [31:0] f);
    fault_sel_t sel;
    sel.site     = f >> 1;
    sel.stuck_hi = f[0];
    return sel;
  endfunction

endpackage

// File: rtl/fault_decoder.sv
// Combinational fault-index decoder: drives at most one stuck control
// across both vectors, and nothing at all when disabled.
module fault_decoder
  import fault_campaign_pkg::*;
#(
  parameter int NSITES = 32,
  parameter int FW     = $clog2(2*NSITES)
) (
  input  logic [FW-1:0]     fault_idx,
  input  logic              en,
  output logic [NSITES-1:0] stuck0_vec,
  output logic [NSITES-1:0] stuck1_vec
);

  fault_sel_t sel;

  assign sel = decode_fault(32'(fault_idx));

  generate
    for (genvar gi = 0; gi < NSITES; gi++) begin : g_site
      assign stuck0_vec[gi] = en && (sel.site == 32'(gi)) && !sel.stuck_hi;
      assign stuck1_vec[gi] = en && (sel.site == 32'(gi)) &&  sel.stuck_hi;
    end
  endgenerate

endmodule

// File: rtl/fault_campaign_ctrl.sv
// Walks every stuck-at fault, resets the faulted/golden DUT pair, compares
// their outputs over a window of valid cycles and reports one result per fault.
module fault_campaign_ctrl
  import fault_campaign_pkg::*;
#(
  parameter int NSITES     = 32,
  parameter int OUTW       = 16,
  parameter int WINDOW     = 256,
  parameter int EARLY_EXIT = 1,
  parameter int FW         = $clog2(2*NSITES),
  parameter int CW         = $clog2(WINDOW)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [NSITES-1:0] stuck0_vec,
  output logic [NSITES-1:0] stuck1_vec,
  output logic              dut_rst,
  input  logic              cmp_valid,
  input  logic [OUTW-1:0]   dut_out,
  input  logic [OUTW-1:0]   gold_out,
  output logic              res_we,
  output logic [FW-1:0]     res_fault,
  output logic              res_detected,
  output logic [CW-1:0]     res_cycle,
  output logic [FW:0]       det_count,
  output logic              busy,
  output logic              done
);

  localparam logic [FW-1:0] LAST_FAULT = FW'(2*NSITES-1);
  localparam logic [CW-1:0] LAST_CYCLE = CW'(WINDOW-1);

  state_t        state_reg;
  logic [FW-1:0] fault_reg;
  logic [CW-1:0] win_cnt_reg;
  logic          det_reg;
  logic [CW-1:0] first_cyc_reg;

  logic          dut_rst_reg;
  logic          busy_reg;
  logic          done_reg;
  logic          res_we_reg;
  logic [FW-1:0] res_fault_reg;
  logic          res_detected_reg;
  logic [CW-1:0] res_cycle_reg;
  logic [FW:0]   det_count_reg;

  logic mismatch;
  logic first_hit;
  logic run_exit;
  logic fault_en;

  assign mismatch  = cmp_valid && (dut_out != gold_out);
  assign first_hit = mismatch && !det_reg;
  assign run_exit  = (cmp_valid && (win_cnt_reg == LAST_CYCLE)) ||
                     ((EARLY_EXIT != 0) && first_hit);
  // Faults are applied only while the DUT is being reset or compared.
  assign fault_en  = (state_reg == RST1) || (state_reg == RST2) || (state_reg == RUN);

  fault_decoder #(
    .NSITES (NSITES),
    .FW     (FW)
  ) u_decoder (
    .fault_idx  (fault_reg),
    .en         (fault_en),
    .stuck0_vec (stuck0_vec),
    .stuck1_vec (stuck1_vec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      fault_reg        <= '0;
      win_cnt_reg      <= '0;
      det_reg          <= 1'b0;
      first_cyc_reg    <= '0;
      dut_rst_reg      <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      res_we_reg       <= 1'b0;
      res_fault_reg    <= '0;
      res_detected_reg <= 1'b0;
      res_cycle_reg    <= '0;
      det_count_reg    <= '0;
    end else if (abort) begin
      // A partially run fault is dropped without a result write.
      state_reg   <= IDLE;
      dut_rst_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      res_we_reg  <= 1'b0;
      win_cnt_reg <= '0;
      det_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg     <= RST1;
            fault_reg     <= '0;
            det_count_reg <= '0;
            dut_rst_reg   <= 1'b1;
            busy_reg      <= 1'b1;
            done_reg      <= 1'b0;
          end
        end
        RST1: begin
          state_reg <= RST2;
        end
        RST2: begin
          state_reg     <= RUN;
          dut_rst_reg   <= 1'b0;
          win_cnt_reg   <= '0;
          det_reg       <= 1'b0;
          first_cyc_reg <= '0;
        end
        RUN: begin
          if (cmp_valid) begin
            win_cnt_reg <= win_cnt_reg + 1'b1;
            if (first_hit) begin
              det_reg       <= 1'b1;
              first_cyc_reg <= win_cnt_reg;
            end
            if (run_exit) begin
              state_reg        <= RECORD;
              res_we_reg       <= 1'b1;
              res_fault_reg    <= fault_reg;
              res_detected_reg <= det_reg || mismatch;
              res_cycle_reg    <= det_reg ? first_cyc_reg :
                                  (mismatch ? win_cnt_reg : '0);
            end
          end
        end
        RECORD: begin
          res_we_reg    <= 1'b0;
          det_count_reg <= det_count_reg + (FW+1)'(res_detected_reg);
          if (fault_reg == LAST_FAULT) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg   <= RST1;
            fault_reg   <= fault_reg + 1'b1;
            dut_rst_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign dut_rst      = dut_rst_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign res_we       = res_we_reg;
  assign res_fault    = res_fault_reg;
  assign res_detected = res_detected_reg;
  assign res_cycle    = res_cycle_reg;
  assign det_count    = det_count_reg;

endmodule
